// File: rtl/cap_switch_sequencer.sv
// Break-before-make sequencer for the capacitor-board switch gates.
// When the decoded board state changes, released switches open first. The design waits a dead time, closes the new switches, then holds for a settle dwell.
module cap_switch_sequencer #(
  parameter int N_SW          = 4,
  parameter int DEAD_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int CW            = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] state_in,
  output logic [N_SW-1:0] sw_drive,
  output logic            busy,
  output logic            update_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_SETTLE
  } state_t;

  localparam logic [CW-1:0] DEAD_LOAD   = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t          r_state;
  logic [N_SW-1:0] r_target;
  logic [N_SW-1:0] r_sw_drive;
  logic [CW-1:0]   r_cnt;
  logic            r_update_done;
  logic [N_SW-1:0] w_off_mask;

  assign w_off_mask = r_sw_drive & ~state_in;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_target      <= '0;
      r_sw_drive    <= '0;
      r_cnt         <= '0;
      r_update_done <= 1'b0;
    end else begin
      r_update_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (state_in != r_sw_drive) begin
            r_target <= state_in;
            if (w_off_mask != '0) begin
              // Open released switches only; bits common to old and new stay closed.
              r_sw_drive <= r_sw_drive & state_in;
              r_cnt      <= DEAD_LOAD;
              r_state    <= ST_DEAD;
            end else begin
              r_sw_drive <= state_in;
              r_cnt      <= SETTLE_LOAD;
              r_state    <= ST_SETTLE;
            end
          end
        end
        ST_DEAD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_sw_drive <= r_target;
            r_cnt      <= SETTLE_LOAD;
            r_state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state       <= ST_IDLE;
            r_update_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sw_drive    = r_sw_drive;
  assign busy        = (r_state != ST_IDLE);
  assign update_done = r_update_done;

endmodule
